// File: rtl/vend_input_conditioner_if.sv
// Signal bundle between the pad-side input conditioner and its consumer.
// master: the side that owns the pads and enable (vending FSM top / test bench).
// slave:  the conditioner itself.
interface vend_input_conditioner_if #(
   parameter int N_IN = 4
);
   logic            ena;        // conditioning enable; low freezes debounce state
   logic [N_IN-1:0] raw_in;     // asynchronous pad inputs
   logic [N_IN-1:0] level_out;  // debounced stable level per channel
   logic [N_IN-1:0] pulse_out;  // one-cycle strobe on each debounced 0->1 flip
   logic            activity;   // some channel has a transition in progress

   modport master (
      output ena,
      output raw_in,
      input  level_out,
      input  pulse_out,
      input  activity
   );

   modport slave (
      input  ena,
      input  raw_in,
      output level_out,
      output pulse_out,
      output activity
   );
endinterface

// File: rtl/vend_input_conditioner.sv
// Pad-input front end for the vending FSM: per channel, a synchroniser chain
// followed by a consecutive-cycle debouncer, producing a clean level and a
// single-cycle rising-edge pulse (bit 0 = m, 1 = a, 2 = btnC, 3 = btnD).
//
// Handshake: pulse_out is a valid-only strobe with no ready. Each bit is high
// for exactly one cycle per debounced press, and the consumer must take it in
// that cycle; there is no back-pressure and no queuing of events.
module vend_input_conditioner #(
   parameter  int N_IN            = 4,
   parameter  int SYNC_STAGES     = 2,
   parameter  int DEBOUNCE_CYCLES = 16,
   localparam int CNT_W           = $clog2(DEBOUNCE_CYCLES)
) (
   input  logic                      clk,
   input  logic                      rst_n,
   vend_input_conditioner_if.slave   bus
);

   // Last count value before the level is allowed to flip.
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

   logic [N_IN-1:0]  sync_q [SYNC_STAGES];
   logic [N_IN-1:0]  sync;
   logic [CNT_W-1:0] cnt_q  [N_IN];
   logic [CNT_W-1:0] cnt_d  [N_IN];
   logic [N_IN-1:0]  level_q, level_d;
   logic [N_IN-1:0]  pulse_q, pulse_d;
   logic             activity_q, activity_d;

   assign sync = sync_q[SYNC_STAGES-1];

   // Synchroniser chain; runs every cycle regardless of ena so the debouncer
   // always sees fresh samples when it resumes.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int s = 0; s < SYNC_STAGES; s++) begin
            sync_q[s] <= '0;
         end
      end else begin
         sync_q[0] <= bus.raw_in;
         for (int s = 1; s < SYNC_STAGES; s++) begin
            sync_q[s] <= sync_q[s-1];
         end
      end
   end

   // Debounce next-state: any cycle where sync agrees with the level restarts
   // the count; the level flips only after DEBOUNCE_CYCLES disagreeing cycles.
   always_comb begin
      level_d    = level_q;
      pulse_d    = '0;
      activity_d = 1'b0;
      for (int i = 0; i < N_IN; i++) begin
         cnt_d[i] = cnt_q[i];
      end
      if (bus.ena) begin
         for (int i = 0; i < N_IN; i++) begin
            if (sync[i] == level_q[i]) begin
               cnt_d[i] = '0;
            end else if (cnt_q[i] == CNT_MAX) begin
               level_d[i] = sync[i];
               cnt_d[i]   = '0;
               // Only a 0->1 flip is an event for the FSM.
               pulse_d[i] = sync[i];
            end else begin
               cnt_d[i] = cnt_q[i] + 1'b1;
            end
         end
      end
      for (int i = 0; i < N_IN; i++) begin
         if (cnt_d[i] != '0) begin
            activity_d = 1'b1;
         end
      end
   end

   // Debounce state and registered outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < N_IN; i++) begin
            cnt_q[i] <= '0;
         end
         level_q    <= '0;
         pulse_q    <= '0;
         activity_q <= 1'b0;
      end else begin
         for (int i = 0; i < N_IN; i++) begin
            cnt_q[i] <= cnt_d[i];
         end
         level_q    <= level_d;
         pulse_q    <= pulse_d;
         activity_q <= activity_d;
      end
   end

   assign bus.level_out = level_q;
   assign bus.pulse_out = pulse_q;
   assign bus.activity  = activity_q;

endmodule

// File: tb/tb_vend_input_conditioner.sv
// Bench for vend_input_conditioner: directed scenarios for the documented
// latencies plus randomized pad activity, all checked cycle by cycle against
// a reference model that treats each channel as "flip after N consecutive
// disagreeing enabled samples of a delayed copy of the pad".
module tb_vend_input_conditioner;

   localparam int N_IN            = 4;
   localparam int SYNC_STAGES     = 2;
   localparam int DEBOUNCE_CYCLES = 16;
   localparam int W               = 2 * N_IN + 1;
   localparam int LAT             = SYNC_STAGES + DEBOUNCE_CYCLES;

   // ---------------- clock / reset ----------------
   logic clk   = 1'b0;
   logic rst_n = 1'b0;

   always #5 clk = ~clk;

   vend_input_conditioner_if #(.N_IN(N_IN)) bus ();

   vend_input_conditioner #(
      .N_IN            (N_IN),
      .SYNC_STAGES     (SYNC_STAGES),
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus.slave)
   );

   // ---------------- scoreboard state ----------------
   int n_cmp  = 0;
   int n_fail = 0;
   int cyc    = 0;

   logic [W-1:0] exp_q[$];

   // ---------------- reference model ----------------
   // Pad samples travel through a SYNC_STAGES-deep delay queue; each channel
   // then counts how many enabled samples in a row disagree with its level.
   logic [N_IN-1:0] m_hist[$];
   logic [N_IN-1:0] m_level;
   int              m_run [N_IN];
   logic [N_IN-1:0] m_seen;
   logic [N_IN-1:0] m_pulse;
   logic            m_act;

   always @(posedge clk) begin
      cyc++;
      m_pulse = '0;
      if (!rst_n) begin
         m_level = '0;
         for (int i = 0; i < N_IN; i++) m_run[i] = 0;
         m_hist.delete();
         for (int s = 0; s < SYNC_STAGES; s++) m_hist.push_back('0);
      end else begin
         m_seen = m_hist.pop_front();
         m_hist.push_back(bus.raw_in);
         if (bus.ena) begin
            for (int i = 0; i < N_IN; i++) begin
               if (m_seen[i] == m_level[i]) begin
                  m_run[i] = 0;
               end else begin
                  m_run[i] = m_run[i] + 1;
                  if (m_run[i] == DEBOUNCE_CYCLES) begin
                     m_level[i] = m_seen[i];
                     m_run[i]   = 0;
                     m_pulse[i] = m_seen[i];
                  end
               end
            end
         end
      end
      m_act = 1'b0;
      for (int i = 0; i < N_IN; i++) if (m_run[i] != 0) m_act = 1'b1;
      exp_q.push_back({m_level, m_pulse, m_act});
   end

   // ---------------- monitor ----------------
   logic [W-1:0]    mon_exp, mon_got;
   logic [N_IN-1:0] prev_pulse = '0;

   always @(negedge clk) begin
      if (exp_q.size() > 0) begin
         mon_exp = exp_q.pop_front();
         mon_got = {bus.level_out, bus.pulse_out, bus.activity};
         n_cmp++;
         if (mon_got !== mon_exp) begin
            n_fail++;
            $display("FAIL cycle_%0d outputs: got level=%b pulse=%b act=%b, expected level=%b pulse=%b act=%b",
                     cyc, mon_got[W-1 -: N_IN], mon_got[N_IN:1], mon_got[0],
                     mon_exp[W-1 -: N_IN], mon_exp[N_IN:1], mon_exp[0]);
         end
         n_cmp++;
         if ((bus.pulse_out & prev_pulse) !== '0) begin
            n_fail++;
            $display("FAIL cycle_%0d back_to_back_pulse: got pulse=%b after %b, expected no repeated bit",
                     cyc, bus.pulse_out, prev_pulse);
         end
         prev_pulse = bus.pulse_out;
      end
   end

   // ---------------- driver / check tasks ----------------
   // All stimulus changes happen 1 time unit after a falling edge, so the
   // next rising edge is "edge #1" relative to the change.
   task automatic step(input int n);
      repeat (n) begin
         @(negedge clk);
         #1;
      end
   endtask

   task automatic check_int(input string name, input int act, input int exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   // Bounded watch of one channel: first edge (relative) with a pulse, number
   // of pulsing cycles, and the full pulse vector seen at the first pulse.
   task automatic watch(input int ch, input int n, output int first, output int count,
                        output logic [N_IN-1:0] vec);
      first = -1;
      count = 0;
      vec   = '0;
      for (int i = 1; i <= n; i++) begin
         step(1);
         if (bus.pulse_out[ch]) begin
            if (first < 0) begin
               first = i;
               vec   = bus.pulse_out;
            end
            count++;
         end
      end
   endtask

   task automatic settle();
      bus.raw_in = '0;
      bus.ena    = 1'b1;
      step(LAT + 8);
   endtask

   // ---------------- stimulus ----------------
   int              first, count;
   logic [N_IN-1:0] vec;
   logic [N_IN-1:0] cur_raw;

   initial begin
      bus.raw_in = 4'b1111;
      bus.ena    = 1'b1;
      rst_n      = 1'b0;
      step(5);

      // Reset with all pads high: everything stays cleared.
      check_int("reset_level",    int'(bus.level_out), 0);
      check_int("reset_pulse",    int'(bus.pulse_out), 0);
      check_int("reset_activity", int'(bus.activity),  0);
      bus.raw_in = 4'b0000;
      rst_n      = 1'b1;
      step(5);
      check_int("post_release_level", int'(bus.level_out), 0);

      // Clean press on ch0: activity over edges 3..17, level and pulse at 18.
      bus.raw_in = 4'b0001;
      first = -1;
      count = 0;
      for (int i = 1; i <= 30; i++) begin
         step(1);
         if (i <= LAT) check_int($sformatf("clean_act_e%0d", i), int'(bus.activity),
                                 (i >= 3 && i < LAT) ? 1 : 0);
         if (bus.pulse_out != '0) begin
            if (first < 0) first = i;
            count++;
            check_int("clean_pulse_vec", int'(bus.pulse_out), 1);
         end
      end
      check_int("clean_pulse_edge",  first, LAT);
      check_int("clean_pulse_count", count, 1);
      check_int("clean_level",       int'(bus.level_out), 1);
      // Release: same latency, no pulse.
      bus.raw_in = 4'b0000;
      step(LAT - 1);
      check_int("fall_level_before", int'(bus.level_out[0]), 1);
      step(1);
      check_int("fall_level_after",  int'(bus.level_out[0]), 0);
      settle();

      // Bounce on ch1: 5-cycle toggles never get through.
      count = 0;
      for (int seg = 0; seg < 12; seg++) begin
         bus.raw_in = (seg % 2 == 0) ? 4'b0010 : 4'b0000;
         for (int k = 0; k < 5; k++) begin
            step(1);
            if (bus.pulse_out[1]) count++;
         end
      end
      check_int("bounce_no_pulse", count, 0);
      check_int("bounce_no_level", int'(bus.level_out[1]), 0);
      bus.raw_in = 4'b0010;
      watch(1, 30, first, count, vec);
      check_int("bounce_settle_edge",  first, LAT);
      check_int("bounce_settle_count", count, 1);
      settle();

      // Simultaneous ch2+ch3: one shared pulse cycle, release is silent.
      bus.raw_in = 4'b1100;
      watch(2, 30, first, count, vec);
      check_int("simul_edge",  first, LAT);
      check_int("simul_vec",   int'(vec), 4'b1100);
      check_int("simul_count", count, 1);
      bus.raw_in = 4'b0000;
      count = 0;
      for (int i = 1; i <= 30; i++) begin
         step(1);
         if (bus.pulse_out != '0) count++;
      end
      check_int("simul_release_pulses", count, 0);
      check_int("simul_release_level",  int'(bus.level_out), 0);
      settle();

      // ena freeze on ch2: 10 enabled edges, 20 frozen, flip at edge 38.
      bus.raw_in = 4'b0100;
      step(10);
      bus.ena = 1'b0;
      count = 0;
      for (int i = 0; i < 20; i++) begin
         step(1);
         if (bus.pulse_out != '0) count++;
      end
      check_int("freeze_no_pulse", count, 0);
      check_int("freeze_level",    int'(bus.level_out[2]), 0);
      check_int("freeze_activity", int'(bus.activity), 1);
      bus.ena = 1'b1;
      watch(2, 20, first, count, vec);
      check_int("freeze_flip_edge", first + 30, 38);
      check_int("freeze_count",     count, 1);
      settle();

      // Reset mid-debounce on ch3: partial count discarded, one pulse later.
      bus.raw_in = 4'b1000;
      step(12);
      check_int("midrst_act_before", int'(bus.activity), 1);
      rst_n = 1'b0;
      #1;
      check_int("midrst_async_act", int'(bus.activity), 0);
      step(3);
      rst_n = 1'b1;
      watch(3, 40, first, count, vec);
      check_int("midrst_pulse_edge",  first, LAT);
      check_int("midrst_pulse_count", count, 1);
      settle();

      // Randomized pads, enable and occasional reset; model checks every cycle.
      cur_raw = '0;
      for (int k = 0; k < 150; k++) begin
         for (int i = 0; i < N_IN; i++) begin
            if ($urandom_range(0, 2) == 0) cur_raw[i] = ~cur_raw[i];
         end
         bus.raw_in = cur_raw;
         bus.ena    = ($urandom_range(0, 5) != 0);
         if ($urandom_range(0, 29) == 0) begin
            rst_n = 1'b0;
            step(2);
            rst_n = 1'b1;
         end
         step($urandom_range(1, 40));
      end
      settle();
      step(4);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
